// File: rtl/drc_pkg.sv
// Shared definitions for the DMA read/write controllers: request word layout,
// data width, AXI attribute constants and the read-master FSM state type.
package drc_pkg;

    localparam int REQ_W    = 40;
    localparam int ADDR_MSB = 39;
    localparam int ADDR_LSB = 8;
    localparam int CNT_MSB  = 7;
    localparam int DATA_W   = 128;

    localparam logic [2:0] SIZE_16B   = 3'b100;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_XIL  = 4'b0011;
    localparam logic [2:0] PROT_NONE  = 3'b000;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/drc_axi_puller_if.sv
// AXI4 read address and read data channels between the puller (master) and
// the interconnect (slave).
interface drc_axi_puller_if;
    import drc_pkg::*;

    // A transfer on AR or R happens on a rising edge where valid and ready
    // are both high; valid, once raised, keeps its payload until that edge.
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arprot, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arprot, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/drc_prio_arb.sv
// Fixed-priority one-hot arbiter: the lowest-index requester wins.
module drc_prio_arb #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    // Scanning downward lets the lowest set index overwrite the others.
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/drc_axi_puller.sv
// AXI4 read master: pops one request at a time, issues a single INCR burst
// and steers the returned beats into the requesting path's data FIFO.
module drc_axi_puller
    import drc_pkg::*;
#(
    parameter int p_paths = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [p_paths-1:0]       paths_req_empty,
    input  logic [p_paths*REQ_W-1:0] paths_req_in,
    output logic [p_paths-1:0]       paths_req_rd,
    input  logic [p_paths-1:0]       paths_data_full,
    output logic [p_paths-1:0]       paths_data_wr,
    output logic [DATA_W-1:0]        paths_data_out,
    drc_axi_puller_if.master         axi,
    output logic                     o_err,
    output logic [p_paths-1:0]       o_err_path,
    output rd_state_e                dbg_state
);

    rd_state_e          state;
    logic [p_paths-1:0] active;
    logic [7:0]         beat_ctr;
    logic [31:0]        araddr_q;
    logic [7:0]         arlen_q;
    logic               arvalid_q;

    logic [p_paths-1:0] gnt;
    logic               any_req;
    logic [REQ_W-1:0]   win_word;
    logic [7:0]         win_cnt;
    logic [31:0]        win_addr;
    logic               pop;
    logic               beat;
    logic               beat_err;

    drc_prio_arb #(.N(p_paths)) u_arb (
        .req (~paths_req_empty),
        .gnt (gnt),
        .any (any_req)
    );

    always_comb begin
        win_word = '0;
        for (int j = 0; j < p_paths; j++) begin
            if (gnt[j]) win_word = paths_req_in[j*REQ_W +: REQ_W];
        end
    end

    assign win_cnt  = win_word[CNT_MSB:0];
    assign win_addr = win_word[ADDR_MSB:ADDR_LSB];

    // Pops and R acceptance are held off while reset is asserted so that a
    // request or beat is never consumed by a cycle that is being discarded.
    assign pop          = (state == ST_IDLE) && any_req && !i_rst;
    assign paths_req_rd = pop ? gnt : '0;

    assign axi.rready     = (state == ST_DATA) && !(|(paths_data_full & active)) && !i_rst;
    assign beat           = axi.rvalid && axi.rready;
    assign paths_data_wr  = beat ? active : '0;
    assign paths_data_out = axi.rdata;

    assign beat_err = (axi.rresp != RESP_OKAY) || (axi.rlast != (beat_ctr == 8'd0));

    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arvalid = arvalid_q;
    assign axi.arsize  = SIZE_16B;
    assign axi.arburst = BURST_INCR;
    assign axi.arcache = CACHE_XIL;
    assign axi.arprot  = PROT_NONE;
    assign dbg_state   = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            active     <= '0;
            beat_ctr   <= 8'd0;
            araddr_q   <= 32'd0;
            arlen_q    <= 8'd0;
            arvalid_q  <= 1'b0;
            o_err      <= 1'b0;
            o_err_path <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        // A zero-length request is dropped and only reported.
                        if (win_cnt == 8'd0) begin
                            if (!o_err) begin
                                o_err      <= 1'b1;
                                o_err_path <= gnt;
                            end
                        end else begin
                            active    <= gnt;
                            araddr_q  <= win_addr;
                            arlen_q   <= win_cnt - 8'd1;
                            beat_ctr  <= win_cnt - 8'd1;
                            arvalid_q <= 1'b1;
                            state     <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        beat_ctr <= beat_ctr - 8'd1;
                        if (beat_err && !o_err) begin
                            o_err      <= 1'b1;
                            o_err_path <= active;
                        end
                        if (beat_ctr == 8'd0) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
